// File: rtl/dec_aes.sv
// Iterative AES-128 inverse cipher: one round key per cycle during expansion, then one inverse round per cycle.
// The expanded schedule can be retained so that repeated blocks under the same key skip expansion.
module dec_aes #(
    parameter bit CACHE_KEY = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);
    typedef enum logic [1:0] {IDLE = 2'd0, KEYEXP = 2'd1, DEC = 2'd2, DONE = 2'd3} fsm_t;

    // Entry 0 sits in the top byte; the lookup indexes from the top by inverting the address.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns except in the final round.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] t;
        logic [127:0] m;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
            end
        end
        t = t ^ rk;
        for (int c = 0; c < 4; c++) begin
            m[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
        end
        return last ? t : m;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] tmp, n0, n1, n2, n3;
        tmp = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        n0  = k[127:96] ^ tmp;
        n1  = k[95:64] ^ n0;
        n2  = k[63:32] ^ n1;
        n3  = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] key_q, key_d;
    logic         cache_vld_q, cache_vld_d;
    logic [127:0] cache_key_q, cache_key_d;
    logic [127:0] out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;
    logic         in_ready_q, in_ready_d;
    logic [127:0] rk_q [0:10];

    logic         hit;
    logic [127:0] exp_key;
    logic [127:0] round_out;

    assign hit       = CACHE_KEY && cache_vld_q && (in_key == cache_key_q);
    assign exp_key   = key_step(rk_q[cnt_q - 4'd1], rcon(cnt_q));
    assign round_out = inv_round(blk_q, rk_q[cnt_q], cnt_q == 4'd0);

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    fsm_d = in_valid ? (hit ? DEC : KEYEXP) : IDLE;
            KEYEXP:  fsm_d = (cnt_q == 4'd10) ? DEC : KEYEXP;
            DEC:     fsm_d = (cnt_q == 4'd0) ? DONE : DEC;
            DONE:    fsm_d = out_ready ? IDLE : DONE;
            default: fsm_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the next state so they come straight off flops
    always_comb begin
        in_ready_d  = (fsm_d == IDLE);
        out_valid_d = (fsm_d == DONE);
    end

    // Datapath next-state: job latch, key expansion bookkeeping, inverse rounds
    always_comb begin
        cnt_d       = cnt_q;
        blk_d       = blk_q;
        ct_d        = ct_q;
        key_d       = key_q;
        cache_vld_d = cache_vld_q;
        cache_key_d = cache_key_q;
        out_data_d  = out_data_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    ct_d  = in_data;
                    key_d = in_key;
                    if (hit) begin
                        blk_d = in_data ^ rk_q[10];
                        cnt_d = 4'd9;
                    end else begin
                        cnt_d = 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            KEYEXP: begin
                if (cnt_q == 4'd10) begin
                    blk_d       = ct_q ^ exp_key;
                    cache_vld_d = 1'b1;
                    cache_key_d = key_q;
                    cnt_d       = 4'd9;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DEC: begin
                blk_d = round_out;
                if (cnt_q == 4'd0) begin
                    out_data_d = round_out;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    cnt_d = cnt_q;
            default: cnt_d = cnt_q;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= 4'd0;
            blk_q       <= 128'd0;
            ct_q        <= 128'd0;
            key_q       <= 128'd0;
            cache_vld_q <= 1'b0;
            cache_key_q <= 128'd0;
            out_data_q  <= 128'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            blk_q       <= blk_d;
            ct_q        <= ct_d;
            key_q       <= key_d;
            cache_vld_q <= cache_vld_d;
            cache_key_q <= cache_key_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Round-key store; contents only matter once written, so no reset
    always_ff @(posedge clk) begin
        if (fsm_q == IDLE && in_valid && !hit) begin
            rk_q[0] <= in_key;
        end else if (fsm_q == KEYEXP) begin
            rk_q[cnt_q] <= exp_key;
        end
    end
endmodule

// File: tb/tb_dec_aes.sv
// Self-checking bench for dec_aes: FIPS-197 vectors, key caching, backpressure, mid-run reset, and
// round trips against an independent behavioural AES-128 encryptor with an algebraically derived S-box.
module tb_dec_aes;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K3 = 128'h1b7c140922ae01a64bf41b8803ba4f4a;
    localparam logic [127:0] P3 = 128'h01071f7f01071f7f00030f3f00030f3f;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         sel = 1'b0;
    logic [127:0] in_data = 128'd0;
    logic [127:0] in_key = 128'd0;
    logic         ir0, ov0, ir1, ov1;
    logic [127:0] od0, od1;
    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    wire iv0 = in_valid & ~sel;
    wire iv1 = in_valid & sel;
    wire or0 = out_ready & ~sel;
    wire or1 = out_ready & sel;
    wire         obs_ready = sel ? ir1 : ir0;
    wire         obs_valid = sel ? ov1 : ov0;
    wire [127:0] obs_data  = sel ? od1 : od0;

    dec_aes #(.CACHE_KEY(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(in_data),
        .in_key(in_key), .out_valid(ov0), .out_ready(or0), .out_data(od0));

    dec_aes #(.CACHE_KEY(1'b0)) u_dut_nc (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(in_data),
        .in_key(in_key), .out_valid(ov1), .out_ready(or1), .out_data(od1));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] sq = x;
        logic [7:0] v = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            v  = gmul(v, sq);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] st, rk, t;
        logic [31:0]  w;
        logic [7:0]   rc, a0, a1, a2, a3;
        rk = key;
        st = pt ^ key;
        rc = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            w  = rk[31:0];
            w  = {ref_sbox(w[23:16]) ^ rc, ref_sbox(w[15:8]), ref_sbox(w[7:0]), ref_sbox(w[31:24])};
            rk[127:96] = rk[127:96] ^ w;
            rk[95:64]  = rk[95:64] ^ rk[127:96];
            rk[63:32]  = rk[63:32] ^ rk[95:64];
            rk[31:0]   = rk[31:0] ^ rk[63:32];
            rc = gmul(rc, 8'h02);
            for (int i = 0; i < 16; i++) st[127-8*i -: 8] = ref_sbox(st[127-8*i -: 8]);
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[127-8*(4*c+r) -: 8] = st[127-8*(4*((c+r)%4)+r) -: 8];
            st = t;
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[127-32*c -: 8];
                    a1 = t[119-32*c -: 8];
                    a2 = t[111-32*c -: 8];
                    a3 = t[103-32*c -: 8];
                    st[127-32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                                          a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                                          a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                                          gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
                end
            end
            st = st ^ rk;
        end
        return st;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic submit(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] pt);
        int w = 0;
        while (obs_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL submit_ready: got %b expected 1", obs_ready);
        end
        in_valid = 1'b1;
        in_data  = ct;
        in_key   = key;
        tick();
        in_valid = 1'b0;
        exp_q.push_back(pt);
    endtask

    task automatic collect(input string name, input int exp_lat);
        int lat = 0;
        logic [127:0] e;
        while (obs_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard: got output with no expectation queued", name);
        end else begin
            e = exp_q.pop_front();
            if (obs_data !== e) begin
                errors++;
                $display("FAIL %s_data: got %h expected %h", name, obs_data, e);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_valid_drop: got %b expected 0", name, obs_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov0); end
        checks++;
        if (od0 !== 128'd0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", od0); end
        checks++;
        if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", ir0); end
    endtask

    task automatic test_cold();
        submit(C1, K1, P1);
        collect("cold", 20);
    endtask

    task automatic test_cache_hit();
        submit(C1, K1, P1);
        collect("hit", 10);
    endtask

    task automatic test_key_change();
        submit(C2, K2, P2);
        collect("keychg", 20);
        submit(C2, K2, P2);
        collect("keychg_hit", 10);
    endtask

    task automatic test_nocache();
        sel = 1'b1;
        submit(C1, K1, P1);
        collect("nocache_first", 20);
        submit(C1, K1, P1);
        collect("nocache_repeat", 20);
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat = 0;
        logic [127:0] e;
        submit(C1, K1, P1);
        while (obs_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 20) begin errors++; $display("FAIL bp_latency: got %0d expected 20", lat); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'd0;
        in_valid = 1'b1;
        in_data  = C1;
        in_key   = K1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs_valid !== 1'b1 || obs_data !== e || obs_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b ready=%b data=%h expected valid=1 ready=0 data=%h",
                         i, obs_valid, obs_ready, obs_data, e);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", obs_valid, obs_ready);
        end
        tick();
        in_valid = 1'b0;
        exp_q.push_back(P1);
        checks++;
        if (obs_ready !== 1'b0) begin errors++; $display("FAIL bp_accept: got ready=%b expected 0", obs_ready); end
        collect("bp_next", 10);
    endtask

    task automatic test_reset_midop();
        int seen = 0;
        submit(C1, K1, P1);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        checks++;
        if (ov0 !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", ov0); end
        checks++;
        if (od0 !== 128'd0) begin errors++; $display("FAIL midrst_out_data: got %h expected 0", od0); end
        checks++;
        if (ir0 !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", ir0); end
        for (int i = 0; i < 25; i++) begin
            tick();
            if (ov0 === 1'b1) seen = 1;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midrst_no_output: got output expected none"); end
        submit(C1, K1, P1);
        collect("midrst_resubmit", 20);
    endtask

    task automatic test_round_trip();
        submit(aes_enc(P3, K3), K3, P3);
        collect("roundtrip", 20);
    endtask

    task automatic test_back_to_back();
        logic [127:0] k, p;
        k = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            submit(aes_enc(p, k), k, p);
            collect("b2b", (i == 0) ? 20 : 10);
        end
    endtask

    initial begin
        test_reset();
        test_cold();
        test_cache_hit();
        test_key_change();
        test_nocache();
        test_backpressure();
        test_reset_midop();
        test_round_trip();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dec_aes.md
Name: dec_aes

Overview:
Iterative AES-128 decryptor (FIPS-197 inverse cipher), the receive-side counterpart of enc_aes in the accelerator's AES path.
- Accepts one 128-bit ciphertext block and 128-bit key per valid/ready handshake and returns the plaintext on a valid/ready output.
- Expands the key schedule on-chip, one round key per cycle.
- Processes one inverse round per cycle.
- Optionally caches the last key schedule so that back-to-back blocks under one key skip expansion.

Parameters:
CACHE_KEY, 1, 1 = keep the expanded schedule and skip expansion when in_key matches the cached key; 0 = always expand.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  ciphertext/key present
in_ready  output  1  block can accept a new job
in_data  input  128  ciphertext; byte 0 = bits [127:120] (FIPS-197 byte order)
in_key  input  128  cipher key, same byte order
out_valid  output  1  plaintext valid
out_ready  input  1  consumer accepts plaintext
out_data  output  128  plaintext, same byte order

Behaviour:
- Clock and reset: one clock (clk). rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - FSM goes to IDLE; in_ready=1 from the next cycle.
  - out_valid=0, out_data=0.
  - Round counter = 0; key-cache valid flag cleared; round-key store is don't-care.
  - Reset wins over every other event, including mid-operation. The aborted job produces no output.
- FSM states: IDLE, KEYEXP, DEC, DONE.
- IDLE:
  - in_ready=1; accept when in_valid=1 at an edge.
  - On accept, latch in_data and in_key.
  - Cache hit (CACHE_KEY=1, cache valid, in_key equals cached key): state reg <= in_data ^ rk10; go to DEC with round=9.
  - Miss: rk0 <= in_key; go to KEYEXP with cnt=1.
- KEYEXP, 10 cycles:
  - Cycle cnt computes rk[cnt] from rk[cnt-1] (RotWord, SubWord, Rcon[cnt] = 01,02,04,08,10,20,40,80,1b,36) and stores it.
  - On cnt=10: state reg <= latched ct ^ rk10, computed combinationally in the same cycle.
  - Also on cnt=10: cache valid <= 1, cached key <= latched key; go to DEC with round=9.
- DEC, 10 cycles, round r = 9..0:
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]) for r>=1.
  - r=0 omits InvMixColumns.
  - After r=0: out_data <= result, out_valid=1, go to DONE.
- DONE:
  - out_valid=1 and out_data held stable until out_ready=1 at an edge.
  - Then out_valid=0 and the FSM returns to IDLE. out_data keeps its last value.
- in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored, with no queueing.
- Latency, counted from the accept edge to the first cycle with out_valid=1:
  - 20 cycles on a cache miss or with CACHE_KEY=0.
  - 10 cycles on a cache hit.
- Throughput: at best one block per latency + 2 cycles (DONE handshake cycle, then IDLE accept cycle).
- A key change always forces a miss. Cached contents survive across jobs and are lost only on reset.
- Inverse S-box: a 256-entry combinational ROM. 16 instances for the datapath plus 4 forward S-boxes for the key schedule.
- GF(2^8) arithmetic: modulo x^8+x^4+x^3+x+1. InvMixColumns coefficients are 0e, 0b, 0d, 09.

Test Plan:
1. Cold FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff; out_valid rises exactly 20 cycles after the accept edge.
2. Repeat the same key/ct immediately (CACHE_KEY=1) -> same plaintext, latency 10. With CACHE_KEY=0 -> latency 20.
3. Key change: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> out_data 3243f6a8885a308d313198a2e0370734, latency 20 (miss).
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid, while driving in_valid=1 with a new block -> out_valid and out_data stable, in_ready=0, the new block is not accepted until the cycle after the output handshake.
5. Reset mid-op: assert rst_n=0 for one cycle during DEC round 5 -> next cycle out_valid=0, out_data=0, in_ready=1. Then resubmit the test 1 vector -> latency 20 (cache cleared), correct plaintext.
6. Round trip: encrypt pt 01071f7f01071f7f00030f3f00030f3f under key 1b7c140922ae01a64bf41b8803ba4f4a with enc_aes, feed the ciphertext to dec_aes -> out_data equals the original pt.
